muxcont_pkt: RTL and testbench

//  Parametrised output-port mux controller for the mesh router; one instance per output port.

---
 rtl/muxcont_pkt_pkg.sv | 29 ++
 rtl/muxcont_pkt_rr_arb.sv | 29 ++
 rtl/muxcont_pkt.sv | 138 +++++++++++++
 tb/tb_muxcont_pkt.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/muxcont_pkt_pkg.sv
// Shared types and helpers for the mesh-router output-port mux controller.
// Port-index constants name the router's five inputs; onehot_idx decodes a one-hot grant.
package muxcont_pkt_pkg;

    localparam int NPORT_DEF = 5;
    localparam int PORTW_DEF = 3;

    localparam int PORT_INJ = 0;
    localparam int PORT_W   = 1;
    localparam int PORT_S   = 2;
    localparam int PORT_E   = 3;
    localparam int PORT_N   = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Index of the highest set bit; callers only pass one-hot or zero vectors.
    function automatic int onehot_idx(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/muxcont_pkt_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, priority starts at ptr_i and wraps.
// Zero latency; no backpressure of its own (the caller decides whether a grant transfers).
module muxcont_pkt_rr_arb #(
    parameter int NPORT = 5,
    parameter int PTRW  = 3
) (
    input  logic [NPORT-1:0] req_i,
    input  logic [PTRW-1:0]  ptr_i,
    output logic [NPORT-1:0] grt_o
);

    int   idx;
    logic found;

    always_comb begin
        grt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NPORT; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NPORT) idx = idx - NPORT;
            if (!found && req_i[idx]) begin
                grt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/muxcont_pkt.sv
// Output-port mux controller: filters by destination, round-robin arbitrates, locks for a packet, gates on credits.
// Grant is zero-latency from req; MUXCONT_MCAST_PRIO_EN gives eligible multicast requests priority in IDLE.
module muxcont_pkt
    import muxcont_pkt_pkg::*;
#(
    parameter int NPORT   = NPORT_DEF,
    parameter int PORTW   = PORTW_DEF,
    parameter int PORTID  = 0,
    parameter int CREDITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORT-1:0]             req,
    input  logic [NPORT*PORTW-1:0]       dst,
    input  logic [NPORT-1:0]             tail,
    input  logic [NPORT-1:0]             mcast,
    input  logic                         credit_ret,
    output logic [NPORT-1:0]             grt,
    output logic [NPORT-1:0]             sel,
    output logic                         fire,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
    output logic                         cred_err
);

    localparam int PTRW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CNTW = $clog2(CREDITS + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(CREDITS);

    state_e            state_q, state_d;
    logic [NPORT-1:0]  sel_q, sel_d;
    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [NPORT-1:0]  elig;
    logic [NPORT-1:0]  arb_req;
    logic [NPORT-1:0]  arb_grt;
    logic [PTRW-1:0]   win_idx;
    logic [PTRW-1:0]   ptr_inc;
    logic              tail_win;
    logic              cred_ok;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NPORT; i++) begin
            elig[i] = req[i] && (dst[i*PORTW +: PORTW] == PORTW'(PORTID));
        end
    end

`ifdef MUXCONT_MCAST_PRIO_EN
    // Unicast inputs are masked out while any eligible multicast request is pending.
    assign arb_req = (|(elig & mcast)) ? (elig & mcast) : elig;
`else
    logic unused_mcast;
    assign unused_mcast = ^mcast;
    assign arb_req      = elig;
`endif

    muxcont_pkt_rr_arb #(
        .NPORT (NPORT),
        .PTRW  (PTRW)
    ) u_rr_arb (
        .req_i (arb_req),
        .ptr_i (ptr_q),
        .grt_o (arb_grt)
    );

    assign cred_ok = (cnt_q != '0);

    always_comb begin
        grt = '0;
        if (!rst) grt = (state_q == LOCKED) ? sel_q : arb_grt;
    end

    assign fire     = (|(grt & req)) && cred_ok;
    assign tail_win = |(grt & tail);
    assign win_idx  = PTRW'(onehot_idx(32'(grt)));
    assign ptr_inc  = (int'(win_idx) == NPORT - 1) ? '0 : win_idx + PTRW'(1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (tail_win) begin
                        ptr_d = ptr_inc;
                    end else begin
                        state_d = LOCKED;
                        sel_d   = grt;
                    end
                end
            end
            LOCKED: begin
                if (fire && tail_win) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    ptr_d   = ptr_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A same-cycle fire and return cancel; a return into a full counter is a protocol error.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (fire && !credit_ret) begin
            cnt_d = cnt_q - CNTW'(1);
        end else if (!fire && credit_ret) begin
            if (cnt_q == CNT_MAX) err_d = 1'b1;
            else                  cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= CNT_MAX;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign sel        = sel_q;
    assign credit_cnt = cnt_q;
    assign cred_err   = err_q;

endmodule

// File: tb/tb_muxcont_pkt.sv
// Directed bench for muxcont_pkt: reset, filtering, round-robin, packet lock, credit stall and saturation, mcast priority.
module tb_muxcont_pkt;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [14:0] dst;
    logic [4:0]  tail;
    logic [4:0]  mcast;
    logic        credit_ret;
    logic [4:0]  grt;
    logic [4:0]  sel;
    logic        fire;
    logic [2:0]  credit_cnt;
    logic        cred_err;

    int checks = 0;
    int passes = 0;

    muxcont_pkt #(
        .NPORT   (5),
        .PORTW   (3),
        .PORTID  (0),
        .CREDITS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .dst        (dst),
        .tail       (tail),
        .mcast      (mcast),
        .credit_ret (credit_ret),
        .grt        (grt),
        .sel        (sel),
        .fire       (fire),
        .credit_cnt (credit_cnt),
        .cred_err   (cred_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; dst = '0; tail = '0; mcast = '0; credit_ret = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 5'b11111; dst = '0; tail = 5'b11111; mcast = '0; credit_ret = 1'b0;
        #1;
        checks++; if (grt !== 5'b00000) $display("FAIL reset_grt grt=%b exp=00000", grt); else passes++;
        checks++; if (fire !== 1'b0) $display("FAIL reset_fire fire=%b exp=0", fire); else passes++;
        cyc();
        cyc();
        checks++; if (credit_cnt !== 3'd4) $display("FAIL reset_cnt cnt=%0d exp=4", credit_cnt); else passes++;
        checks++; if (sel !== 5'b00000) $display("FAIL reset_sel sel=%b exp=00000", sel); else passes++;
        checks++; if (cred_err !== 1'b0) $display("FAIL reset_err err=%b exp=0", cred_err); else passes++;
        rst = 1'b0; req = '0; tail = '0;
        cyc();
    endtask

    task automatic test_filter();
        do_reset();
        req = 5'b00010; tail = 5'b00010; dst = 15'h0010; // input 1 headed to port 2
        #1;
        checks++; if (grt !== 5'b00000) $display("FAIL filter_grt grt=%b exp=00000", grt); else passes++;
        checks++; if (fire !== 1'b0) $display("FAIL filter_fire fire=%b exp=0", fire); else passes++;
        dst = '0;
        #1;
        checks++; if (grt !== 5'b00010) $display("FAIL filter_match grt=%b exp=00010", grt); else passes++;
        req = '0; tail = '0;
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_g [5];
        logic       exp_f [5];
        exp_g = '{5'b00010, 5'b01000, 5'b10000, 5'b00010, 5'b01000};
        exp_f = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        req = 5'b11010; tail = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (grt !== exp_g[i]) $display("FAIL rr_grt%0d grt=%b exp=%b", i, grt, exp_g[i]); else passes++;
            checks++; if (fire !== exp_f[i]) $display("FAIL rr_fire%0d fire=%b exp=%b", i, fire, exp_f[i]); else passes++;
            cyc();
        end
        checks++; if (credit_cnt !== 3'd0) $display("FAIL rr_cnt cnt=%0d exp=0", credit_cnt); else passes++;
        req = '0; tail = '0;
    endtask

    task automatic test_packet_lock();
        do_reset();
        req = 5'b00100; tail = 5'b00000;
        #1;
        checks++; if (grt !== 5'b00100 || fire !== 1'b1) $display("FAIL lock_head grt=%b fire=%b exp=00100/1", grt, fire); else passes++;
        cyc();
        checks++; if (sel !== 5'b00100) $display("FAIL lock_sel sel=%b exp=00100", sel); else passes++;
        req = 5'b00001; tail = 5'b00001;
        #1;
        checks++; if (grt !== 5'b00100 || fire !== 1'b0) $display("FAIL lock_bubble grt=%b fire=%b exp=00100/0", grt, fire); else passes++;
        cyc();
        req = 5'b00101;
        #1;
        checks++; if (grt !== 5'b00100 || fire !== 1'b1) $display("FAIL lock_body grt=%b fire=%b exp=00100/1", grt, fire); else passes++;
        cyc();
        tail = 5'b00101;
        #1;
        checks++; if (grt !== 5'b00100 || fire !== 1'b1) $display("FAIL lock_tail grt=%b fire=%b exp=00100/1", grt, fire); else passes++;
        cyc();
        checks++; if (sel !== 5'b00000) $display("FAIL lock_release sel=%b exp=00000", sel); else passes++;
        req = 5'b00001;
        #1;
        checks++; if (grt !== 5'b00001 || fire !== 1'b1) $display("FAIL lock_next grt=%b fire=%b exp=00001/1", grt, fire); else passes++;
        cyc();
        req = '0; tail = '0;
    endtask

    task automatic test_credit_stall();
        do_reset();
        req = 5'b00010; tail = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (fire !== 1'b1) $display("FAIL stall_fire%0d fire=%b exp=1", i, fire); else passes++;
            cyc();
        end
        checks++; if (credit_cnt !== 3'd0) $display("FAIL stall_cnt0 cnt=%0d exp=0", credit_cnt); else passes++;
        #1;
        checks++; if (fire !== 1'b0 || grt !== 5'b00010) $display("FAIL stall_hold grt=%b fire=%b exp=00010/0", grt, fire); else passes++;
        checks++; if (sel !== 5'b00010) $display("FAIL stall_sel sel=%b exp=00010", sel); else passes++;
        credit_ret = 1'b1;
        cyc();
        credit_ret = 1'b0;
        checks++; if (credit_cnt !== 3'd1) $display("FAIL stall_ret cnt=%0d exp=1", credit_cnt); else passes++;
        #1;
        checks++; if (fire !== 1'b1) $display("FAIL stall_one_more fire=%b exp=1", fire); else passes++;
        cyc();
        #1;
        checks++; if (fire !== 1'b0) $display("FAIL stall_again fire=%b exp=0", fire); else passes++;
        req = '0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 5'b00010; tail = 5'b00010;
        cyc();
        cyc();
        checks++; if (credit_cnt !== 3'd2) $display("FAIL sim_pre cnt=%0d exp=2", credit_cnt); else passes++;
        credit_ret = 1'b1;
        #1;
        checks++; if (fire !== 1'b1) $display("FAIL sim_fire fire=%b exp=1", fire); else passes++;
        cyc();
        checks++; if (credit_cnt !== 3'd2) $display("FAIL sim_both cnt=%0d exp=2", credit_cnt); else passes++;
        req = '0;
        cyc();
        cyc();
        checks++; if (credit_cnt !== 3'd4 || cred_err !== 1'b0) $display("FAIL sim_full cnt=%0d err=%b exp=4/0", credit_cnt, cred_err); else passes++;
        cyc();
        credit_ret = 1'b0;
        checks++; if (credit_cnt !== 3'd4 || cred_err !== 1'b1) $display("FAIL sim_over cnt=%0d err=%b exp=4/1", credit_cnt, cred_err); else passes++;
        cyc();
        cyc();
        checks++; if (cred_err !== 1'b1) $display("FAIL sim_sticky err=%b exp=1", cred_err); else passes++;
        do_reset();
        checks++; if (cred_err !== 1'b0) $display("FAIL sim_clear err=%b exp=0", cred_err); else passes++;
        tail = '0;
    endtask

    task automatic test_mcast();
        logic [4:0] exp_g;
`ifdef MUXCONT_MCAST_PRIO_EN
        exp_g = 5'b01000;
`else
        exp_g = 5'b00001;
`endif
        do_reset();
        req = 5'b01001; mcast = 5'b01000; tail = 5'b01001;
        #1;
        checks++; if (grt !== exp_g) $display("FAIL mcast_grt grt=%b exp=%b", grt, exp_g); else passes++;
        req = '0; mcast = '0; tail = '0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_filter();
        test_round_robin();
        test_packet_lock();
        test_credit_stall();
        test_simultaneous();
        test_mcast();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
